// File: rtl/alu_share_pkg.sv
// alu_share_pkg: opcode type, datapath widths and the shared ALU function
// used by alu_share_arbiter.
package alu_share_pkg;

    localparam int OPND_W = 32;
    localparam int RES_W  = 64;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ALU_ADD       = 2'd0,
        ALU_SUB       = 2'd1,
        ALU_2A_PLUS_B = 2'd2,
        ALU_B_MINUS_A = 2'd3
    } alu_op_e;

    typedef struct packed {
        alu_op_e           op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } alu_req_t;

    function automatic logic [RES_W-1:0] alu_compute(
        input alu_op_e           op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        logic [RES_W-1:0] ea;
        logic [RES_W-1:0] eb;
        logic [RES_W-1:0] z;
        ea = {{(RES_W-OPND_W){1'b0}}, a};
        eb = {{(RES_W-OPND_W){1'b0}}, b};
        unique case (op)
            ALU_ADD:       z = ea + eb;
            ALU_SUB:       z = ea - eb;
            ALU_2A_PLUS_B: z = (ea << 1) + eb;
            ALU_B_MINUS_A: z = eb - ea;
            default:       z = '0;
        endcase
        return z;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered pointer
// that moves just past the winner on every accepted grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   cand;
    logic          found;

    // Scan N candidates starting at the pointer, wrapping modulo N.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (enable && !found && req[cand[IW-1:0]]) begin
                found                  = 1'b1;
                grant_idx              = cand[IW-1:0];
                grant[cand[IW-1:0]]    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (grant_idx == IW'(N-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 4-function ALU behind a
// two-stage pipeline. Optional counters: define ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*2-1:0]      req_op,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [RES_W-1:0]          resp_z
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt,
    output logic [CNT_W-1:0]          stall_cnt
`endif
);

    logic               adv1;
    logic               adv2;
    logic               arb_en;
    logic               hs;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    alu_req_t           sel_req;

    logic               s1_vld_q;
    logic               s1_vld_d;
    alu_req_t           s1_req_q;
    alu_req_t           s1_req_d;
    logic [ID_W-1:0]    s1_id_q;
    logic [ID_W-1:0]    s1_id_d;

    logic               s2_vld_q;
    logic               s2_vld_d;
    logic [RES_W-1:0]   s2_z_q;
    logic [RES_W-1:0]   s2_z_d;
    logic [ID_W-1:0]    s2_id_q;
    logic [ID_W-1:0]    s2_id_d;

    assign adv2   = !s2_vld_q || resp_ready;
    assign adv1   = !s1_vld_q || adv2;
    // No grant may be offered while reset is held.
    assign arb_en = adv1 && !reset;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .enable    (arb_en),
        .advance   (hs),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req_ready = grant;
    assign hs        = |(grant & req_valid);

    always_comb begin
        sel_req.op = alu_op_e'(req_op[int'(gidx)*2 +: 2]);
        sel_req.a  = req_a[int'(gidx)*OPND_W +: OPND_W];
        sel_req.b  = req_b[int'(gidx)*OPND_W +: OPND_W];
    end

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_req_d = s1_req_q;
        s1_id_d  = s1_id_q;
        if (adv1) begin
            s1_vld_d = hs;
            if (hs) begin
                s1_req_d = sel_req;
                s1_id_d  = gidx;
            end
        end
    end

    always_comb begin
        s2_vld_d = s2_vld_q;
        s2_z_d   = s2_z_q;
        s2_id_d  = s2_id_q;
        if (adv2) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_z_d  = alu_compute(s1_req_q.op, s1_req_q.a, s1_req_q.b);
                s2_id_d = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_req_q <= '0;
            s1_id_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_z_q   <= '0;
            s2_id_q  <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_req_q <= s1_req_d;
            s1_id_q  <= s1_id_d;
            s2_vld_q <= s2_vld_d;
            s2_z_q   <= s2_z_d;
            s2_id_q  <= s2_id_d;
        end
    end

    assign resp_valid = s2_vld_q;
    assign resp_id    = s2_id_q;
    assign resp_z     = s2_z_q;

`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] gcnt_q;
    logic [NUM_REQ-1:0][CNT_W-1:0] gcnt_d;
    logic [CNT_W-1:0]              stall_q;
    logic [CNT_W-1:0]              stall_d;

    always_comb begin
        gcnt_d  = gcnt_q;
        stall_d = stall_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && req_valid[i]) begin
                gcnt_d[i] = sat_inc(gcnt_q[i]);
            end
        end
        if (resp_valid && !resp_ready) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            gcnt_q  <= gcnt_d;
            stall_q <= stall_d;
        end
    end

    assign grant_cnt = gcnt_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with a scoreboard queue filled on
// request handshakes and drained by an independent response monitor.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*2-1:0]  req_op;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [IW-1:0]   resp_id;
    logic [63:0]     resp_z;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     stall_cnt;
`endif

    typedef struct packed {
        logic [IW-1:0] id;
        logic [63:0]   z;
    } exp_t;

    logic [1:0]  op_r  [N] = '{default: '0};
    logic [31:0] a_r   [N] = '{default: '0};
    logic [31:0] b_r   [N] = '{default: '0};
    logic [63:0] exp_z [N] = '{default: '0};
    int          cnt   [N] = '{default: 0};

    exp_t sb[$];
    int   grant_log[$];
    int   resp_cyc[$];
    int   cyc = 0;
    int   hs_cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_z     (resp_z)
`ifdef ALU_SHARE_ARBITER_STATS_EN
        ,
        .grant_cnt  (grant_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i*2 +: 2]  = op_r[i];
            req_a[i*32 +: 32] = a_r[i];
            req_b[i*32 +: 32] = b_r[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Request side: on each handshake, queue the hand-computed result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (|req_ready) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 1);
                chk("ready_needs_valid", 64'(req_ready & ~req_valid), 0);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = IW'(i);
                    e.z  = exp_z[i];
                    sb.push_back(e);
                    grant_log.push_back(i);
                    hs_cyc = cyc;
                    if (cnt[i] > 0) cnt[i]--;
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid) begin
            chk("resp_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                if (resp_ready) begin
                    e = sb.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_z", resp_z, e.z);
                    resp_cyc.push_back(cyc);
                end else begin
                    chk("stall_id", 64'(resp_id), 64'(sb[0].id));
                    chk("stall_z", resp_z, sb[0].z);
                end
            end
        end
    end

    // Valid stays up while a requester still has accepts outstanding.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) req_valid[i] = (cnt[i] != 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic busy();
        logic b;
        b = (sb.size() != 0);
        for (int i = 0; i < N; i++) if (cnt[i] != 0) b = 1'b1;
        return b;
    endfunction

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] z, input int n);
        op_r[i]      = op;
        a_r[i]       = a;
        b_r[i]       = b;
        exp_z[i]     = z;
        cnt[i]       = n;
        req_valid[i] = 1'b1;
    endtask

    task automatic drain(input string name, input int maxc);
        int k;
        k = 0;
        while (k < maxc && busy()) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_drain_timeout"}, 64'(busy()), 0);
    endtask

    task automatic wait_resp(input string name, input int maxc);
        int k;
        k = 0;
        while (k < maxc && !resp_valid) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_resp_timeout"}, 64'(resp_valid), 1);
    endtask

    // Called at posedge+3; checks the asynchronous effect of reset.
    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        req_valid = '0;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_resp_id", 64'(resp_id), 0);
        chk("rst_resp_z", resp_z, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        grant_log.delete();
        resp_cyc.delete();
    endtask

    initial begin
        int lat;
        int exp_order[8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset state, with every requester asserting valid.
        @(posedge clk);
        #2;
        req_valid = '1;
        #1;
        chk("init_req_ready", 64'(req_ready), 0);
        chk("init_resp_valid", 64'(resp_valid), 0);
        chk("init_resp_z", resp_z, 0);
        req_valid = '0;
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Single request and its latency.
        @(posedge clk);
        #3;
        resp_cyc.delete();
        set_req(2, 2'd0, 32'hFFFF_FFFF, 32'd1, 64'h1_0000_0000, 1);
        drain("t1", 20);
        lat = (resp_cyc.size() > 0) ? resp_cyc[resp_cyc.size()-1] - hs_cyc : -1;
        chk("t1_latency", 64'(lat), 2);

        // Opcodes 1..3 on requester 0.
        @(posedge clk);
        #3;
        set_req(0, 2'd1, 32'd1, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        drain("t2_sub", 20);
        @(posedge clk);
        #3;
        set_req(0, 2'd2, 32'h8000_0000, 32'd3, 64'h1_0000_0003, 1);
        drain("t2_2apb", 20);
        @(posedge clk);
        #3;
        set_req(0, 2'd3, 32'd5, 32'd9, 64'd4, 1);
        drain("t2_bma", 20);

        // Fairness with all requesters busy.
        @(posedge clk);
        #3;
        do_reset();
        @(posedge clk);
        #3;
        set_req(0, 2'd0, 32'd10, 32'd20, 64'd30, 2);
        set_req(1, 2'd1, 32'd7, 32'd3, 64'd4, 2);
        set_req(2, 2'd2, 32'd3, 32'd4, 64'd10, 2);
        set_req(3, 2'd3, 32'd2, 32'd10, 64'd8, 2);
        drain("t3", 40);
        chk("t3_grants", 64'(grant_log.size()), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3_order%0d", k),
                64'((k < grant_log.size()) ? grant_log[k] : -1),
                64'(exp_order[k]));
        end
        chk("t3_throughput",
            64'((resp_cyc.size() == 8) ? resp_cyc[7] - resp_cyc[0] : -1), 7);

        // Backpressure with three requests.
        @(posedge clk);
        #3;
        do_reset();
        @(posedge clk);
        #3;
        resp_ready = 1'b0;
        set_req(0, 2'd0, 32'd100, 32'd1, 64'd101, 1);
        set_req(1, 2'd1, 32'd0, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        set_req(2, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h2_FFFF_FFFD, 1);
        wait_resp("t4", 10);
        for (int s = 0; s < 5; s++) begin
            chk("t4_ready_blocked", 64'(req_ready), 0);
            if (s < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain("t4", 20);
        chk("t4_resp_count", 64'(resp_cyc.size()), 3);

        // Reset with both stages full.
        @(posedge clk);
        #3;
        do_reset();
        @(posedge clk);
        #3;
        resp_ready = 1'b0;
        set_req(0, 2'd0, 32'd1, 32'd1, 64'd2, 1);
        set_req(1, 2'd0, 32'd2, 32'd2, 64'd4, 1);
        for (int k = 0; k < 10 && (cnt[0] != 0 || cnt[1] != 0); k++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        chk("t5_full", 64'(resp_valid), 1);
        #1;
        do_reset();
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_idle", 64'(resp_valid), 0);
        end
        @(posedge clk);
        #3;
        set_req(1, 2'd3, 32'd1, 32'd100, 64'd99, 1);
        set_req(3, 2'd0, 32'd5, 32'd6, 64'd11, 1);
        drain("t5", 20);
        chk("t5_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 1);
        chk("t5_second", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 3);

`ifdef ALU_SHARE_ARBITER_STATS_EN
        // Counters: 5 grants to requester 1, 3 stall cycles.
        @(posedge clk);
        #3;
        do_reset();
        @(posedge clk);
        #3;
        set_req(1, 2'd0, 32'd1, 32'd1, 64'd2, 4);
        drain("t6_a", 30);
        @(posedge clk);
        #3;
        resp_ready = 1'b0;
        set_req(1, 2'd0, 32'd1, 32'd1, 64'd2, 1);
        wait_resp("t6", 10);
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain("t6_b", 20);
        chk("t6_gcnt0", 64'(grant_cnt[15:0]), 0);
        chk("t6_gcnt1", 64'(grant_cnt[31:16]), 5);
        chk("t6_gcnt2", 64'(grant_cnt[47:32]), 0);
        chk("t6_gcnt3", 64'(grant_cnt[63:48]), 0);
        chk("t6_stall", 64'(stall_cnt), 3);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 4-function 32-bit arithmetic unit among NUM_REQ requesters; the function is selected at run time, not by parameter.
- Round-robin arbitration, valid/ready handshakes on every requester port and on the single response port.
- Two-stage pipeline with full backpressure; the ID tag on each response routes the result back to its requester.

Parameters:
- NUM_REQ, 4, number of requester ports (2..16).
- ID_W, $clog2(NUM_REQ), width of the response ID tag.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit is high per cycle.
- req_op  in  NUM_REQ*2  per-requester opcode, packed; slice i is requester i.
- req_a  in  NUM_REQ*32  per-requester operand a, packed.
- req_b  in  NUM_REQ*32  per-requester operand b, packed.
- resp_valid  out  1  result valid.
- resp_ready  in  1  downstream accept.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_z  out  64  result.

Behaviour:
- Reset (async assert; effect is immediate, independent of clk):
  - Both pipeline stages empty; resp_valid=0, resp_id=0, resp_z=0.
  - req_ready=0; RR pointer=0; stats counters=0.
- Opcodes. Operands are zero-extended to 64 bits; all arithmetic is mod 2^64.
  - 0: z=a+b
  - 1: z=a-b
  - 2: z=(a<<1)+b
  - 3: z=b-a
- Pipeline flow:
  - S1 holds {op,a,b,id} of the granted request; S2 holds {z,id}, which drives the resp_* outputs.
  - adv2 = S2 empty OR resp_ready.
  - adv1 = S1 empty OR adv2.
  - On adv2, S2 takes S1's computed result; if S1 is empty, S2 becomes empty.
- Arbitration:
  - Combinational each cycle. When adv1=1 and any req_valid is set, grant the first valid index at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only; req_ready is all-zero when adv1=0.
  - Handshake = req_valid[g]&req_ready[g]. It loads S1, and the RR pointer becomes (g+1) mod NUM_REQ.
  - With no handshake, the pointer holds.
  - If adv1=1 but no request is valid, S1 becomes empty.
- Latency: a handshake in cycle N gives resp_valid in cycle N+2 when resp_ready stays high.
- Throughput: 1 result per cycle with continuous resp_ready.
- Backpressure:
  - While resp_valid=1 and resp_ready=0, resp_id and resp_z hold stable.
  - When S1 is also full, req_ready is all-zero.
  - No request is lost or duplicated.
- Requester rules:
  - A requester keeps req_valid and its operands stable until it is accepted.
  - The arbiter may grant a different requester while one waits. Round-robin bounds the wait at NUM_REQ-1 other grants.
- Simultaneous events: a response handshake and a new request handshake in the same cycle are both honoured, and the pipeline shifts.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no response is issued for them.

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt, width NUM_REQ*16: one 16-bit counter per requester, incremented on that requester's request handshake. Counters saturate at 16'hFFFF and clear on reset.
  - Adds output stall_cnt, width 16: counts cycles with resp_valid=1 and resp_ready=0. Saturating, cleared on reset.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package alu_share_pkg:
  - typedef enum logic [1:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_2A_PLUS_B, ALU_B_MINUS_A}.
  - Constants OPND_W=32 and RES_W=64.
  - Function alu_compute(op,a,b) returning logic [63:0].
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], enable, advance.
  - Outputs: one-hot grant[N] and grant_idx.
  - Owns the RR pointer register.

Test Plan:
1. Single request, resp_ready=1. Requester 2 sends op=0, a=32'hFFFF_FFFF, b=1 (cycle 0) -> resp_valid in cycle 2 with resp_id=2 and resp_z=64'h1_0000_0000.
2. Opcode coverage on requester 0:
   - op=1, a=1, b=2 -> resp_z=64'hFFFF_FFFF_FFFF_FFFF.
   - op=2, a=32'h8000_0000, b=3 -> resp_z=64'h1_0000_0003.
   - op=3, a=5, b=9 -> resp_z=4.
3. Fairness: all 4 requesters hold req_valid continuously for 8 accepts -> grant order 0,1,2,3,0,1,2,3; resp_id follows the same order, one response per cycle.
4. Backpressure: 3 requests issued, resp_ready held 0 for 5 cycles ->
   - resp_z/resp_id stable throughout; req_ready all-zero once S1 fills (2 requests in flight).
   - After resp_ready=1, all 3 results arrive in order with none lost.
5. Reset mid-operation: assert reset with both stages full, deassert, then idle -> resp_valid=0 immediately and stays 0; the next request's result is correct and the RR pointer restarts at 0.
6. With ALU_SHARE_ARBITER_STATS_EN: 5 grants to requester 1 and 3 stall cycles -> grant_cnt[1]=5, other counters 0, stall_cnt=3.
